bfp16_norm_seq: RTL and testbench
=================================

// Module: bfp16_norm_seq
// PURPOSE
//  Multi-cycle normalisation sequencer for the BFP16 add path.
//  - Walks a DATA_W-bit mantissa one byte per cycle, starting at the MSB byte, through a
//    single shared 8-bit leading-one detector, and accumulates the leading-zero count.
//  - Then left-shifts the mantissa and decrements the exponent.
//  - Sits between the BFP16 adder's raw sum stage and the rounding/pack stage.
//  - Uses a valid/ready handshake on both sides.
// PARAMETERS
//  DATA_W  16  mantissa width; must be a multiple of 8
//  EXP_W    8  exponent width
//  (derived) NB = DATA_W/8 bytes; LZ_W = $clog2(DATA_W+1)
// PORTS
//  i_clk         in   1       clock; all logic on the rising edge
//  i_rst         in   1       synchronous, active-high reset
//  i_valid       in   1       upstream operand valid
//  o_ready       out  1       block can accept an operand (high only in IDLE)
//  i_mant        in   DATA_W  un-normalised mantissa
//  i_exp         in   EXP_W   exponent paired with i_mant (unsigned, biased)
//  o_valid       out  1       result valid; held until accepted
//  i_ready       in   1       downstream accepts the result
//  o_mant        out  DATA_W  normalised mantissa
//  o_exp         out  EXP_W   adjusted exponent
//  o_zero        out  1       input mantissa was all zero
//  o_underflow   out  1       shift was clamped by the exponent
// BEHAVIOUR
//  Reset: state=IDLE. o_ready=1. o_valid=0. o_mant=0, o_exp=0, o_zero=0, o_underflow=0.
//  - Internal mant/exp/lz/byte-index registers are cleared.
//  Reset mid-operation: the in-flight operand is discarded with no output.
//  - The cycle after reset deasserts, the block is in IDLE.
//  FSM states: IDLE -> SCAN -> SHIFT -> DONE -> IDLE.
//  IDLE: on i_valid & o_ready, register i_mant and i_exp, set lz=0, set idx=NB-1, go to SCAN.
//  SCAN: drive detector with byte mant[8*idx+:8].
//  - Detector returns pos = leading-zero count of the byte (0..7), plus a zero flag.
//  - Byte zero and idx>0: lz += 8, idx -= 1, stay in SCAN.
//  - Byte non-zero: lz += pos, go to SHIFT.
//  - Byte zero and idx==0: all bytes zero; set zero flag, go to SHIFT.
//  SHIFT (single cycle): sh = (lz >= exp) ? exp : lz.
//  - o_mant = mant << sh.
//  - o_exp = exp - sh.
//  - o_underflow = (lz >= exp) & ~zero.
//  - If zero: o_mant=0, o_exp=0, o_zero=1, o_underflow=0.
//  - Go to DONE with o_valid=1.
//  DONE: outputs held stable while i_ready=0.
//  - On i_ready, o_valid drops next cycle and the block returns to IDLE.
//  - No same-cycle re-accept: o_ready=0 in DONE.
//  Latency: operand accepted in cycle T; o_valid first high in cycle T+k+3.
//  - k = number of all-zero bytes above the first non-zero byte (0..NB-1).
//  - All-zero input behaves as k=NB-1.
//  Throughput: one operand per (k+4) cycles minimum.
//  Widths: lz counts 0..DATA_W in LZ_W bits; the exponent subtract never wraps (clamped).
//  Inputs are ignored outside IDLE. i_mant/i_exp need only be stable in the accept cycle.
// STRUCTURE
//  Shared package bfp16_pkg:
//  - state enum t_norm_state {IDLE, SCAN, SHIFT, DONE}
//  - localparams BYTE_W=8 and LOPD_ZERO_POS=3'b111
//  Sub-module: one instance of the existing LOPD_8bit. No other sub-modules.
//  - Byte mux, lz accumulator and barrel shifter are inline.
// TESTING (DATA_W=16, EXP_W=8)
//  1. mant=16'h8000, exp=10 -> T+3: o_mant=16'h8000, o_exp=10, o_zero=0, o_underflow=0.
//  2. mant=16'h0013, exp=20 -> lz=11; T+4: o_mant=16'h9800, o_exp=9.
//  3. mant=16'h0000, exp=5 -> T+4: o_zero=1, o_mant=0, o_exp=0, o_underflow=0.
//  4. mant=16'h0100, exp=3 -> lz=7 clamped to 3; T+3: o_mant=16'h0800, o_exp=0, o_underflow=1.
//  5. Backpressure: hold i_ready=0 for 5 cycles in DONE.
//     - Outputs stable, o_ready=0, new i_valid ignored.
//     - After i_ready=1: o_valid=0 and o_ready=1 next cycle.
//  6. Assert i_rst during SCAN of 16'h0001 -> next cycle o_valid=0, o_ready=1.
//     - A following op 16'h4000/exp 7 yields 16'h8000/exp 6 at T+3.

Source files
------------

// File: rtl/bfp16_pkg.sv
`default_nettype none
// ============================================================================
// Module : bfp16_pkg
// Brief  : Shared types and constants for the BFP16 add-path normaliser.
// Rev    : 1.0
// ============================================================================
package bfp16_pkg;

   localparam int         BYTE_W        = 8;
   localparam logic [2:0] LOPD_ZERO_POS = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } t_norm_state;

endpackage
`default_nettype wire

// File: rtl/LOPD_8bit.sv
`default_nettype none
// ============================================================================
// Module : LOPD_8bit
// Brief  : Leading-one position detector for one byte (returns leading-zero count).
// Rev    : 1.0
// ============================================================================
module LOPD_8bit
   import bfp16_pkg::*;
(
   input  logic [7:0] i_byte,
   output logic [2:0] o_pos,
   output logic       o_zero
);

   // Scanning LSB upwards lets the highest set bit win the final assignment.
   always_comb begin
      o_pos = LOPD_ZERO_POS;
      for (int i = 0; i < 8; i++) begin
         if (i_byte[i]) begin
            o_pos = 3'(7 - i);
         end
      end
   end

   assign o_zero = ~|i_byte;

endmodule
`default_nettype wire

// File: rtl/bfp16_norm_seq.sv
`default_nettype none
// ============================================================================
// Module : bfp16_norm_seq
// Brief  : Byte-serial leading-zero scan, then left-shift with exponent clamp.
// Rev    : 1.0
// ============================================================================
module bfp16_norm_seq
   import bfp16_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int EXP_W  = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_mant,
   input  logic [EXP_W-1:0]  i_exp,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_mant,
   output logic [EXP_W-1:0]  o_exp,
   output logic              o_zero,
   output logic              o_underflow
);

   localparam int NB    = DATA_W / BYTE_W;
   localparam int LZ_W  = $clog2(DATA_W + 1);
   localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
   localparam int CMP_W = (LZ_W > EXP_W) ? LZ_W : EXP_W;

   t_norm_state       state_q, state_d;
   logic [DATA_W-1:0] mant_q, mant_d;
   logic [EXP_W-1:0]  exp_q, exp_d;
   logic [LZ_W-1:0]   lz_q, lz_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              zero_q, zero_d;
   logic [DATA_W-1:0] omant_q, omant_d;
   logic [EXP_W-1:0]  oexp_q, oexp_d;
   logic              ozero_q, ozero_d;
   logic              ounf_q, ounf_d;

   logic [BYTE_W-1:0] w_byte;
   logic [2:0]        w_pos;
   logic              w_byte_zero;
   logic [CMP_W-1:0]  w_lz_ext, w_exp_ext, w_sh;
   logic              w_clamp;

   always_comb begin
      w_byte = '0;
      for (int b = 0; b < NB; b++) begin
         if (idx_q == IDX_W'(b)) begin
            w_byte = mant_q[b*BYTE_W +: BYTE_W];
         end
      end
   end

   LOPD_8bit u_lopd (
      .i_byte (w_byte),
      .o_pos  (w_pos),
      .o_zero (w_byte_zero)
   );

   // The shift is limited to the exponent so the subtract can never wrap.
   assign w_lz_ext  = CMP_W'(lz_q);
   assign w_exp_ext = CMP_W'(exp_q);
   assign w_clamp   = (w_lz_ext >= w_exp_ext);
   assign w_sh      = w_clamp ? w_exp_ext : w_lz_ext;

   always_comb begin
      state_d = state_q;
      mant_d  = mant_q;
      exp_d   = exp_q;
      lz_d    = lz_q;
      idx_d   = idx_q;
      zero_d  = zero_q;
      omant_d = omant_q;
      oexp_d  = oexp_q;
      ozero_d = ozero_q;
      ounf_d  = ounf_q;
      case (state_q)
         IDLE: begin
            if (i_valid) begin
               mant_d  = i_mant;
               exp_d   = i_exp;
               lz_d    = '0;
               idx_d   = IDX_W'(NB - 1);
               zero_d  = 1'b0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (!w_byte_zero) begin
               lz_d    = lz_q + LZ_W'(w_pos);
               state_d = SHIFT;
            end else if (idx_q != '0) begin
               lz_d  = lz_q + LZ_W'(BYTE_W);
               idx_d = idx_q - IDX_W'(1);
            end else begin
               lz_d    = lz_q + LZ_W'(BYTE_W);
               zero_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (zero_q) begin
               omant_d = '0;
               oexp_d  = '0;
               ozero_d = 1'b1;
               ounf_d  = 1'b0;
            end else begin
               omant_d = mant_q << w_sh;
               oexp_d  = exp_q - EXP_W'(w_sh);
               ozero_d = 1'b0;
               ounf_d  = w_clamp;
            end
            state_d = DONE;
         end
         DONE: begin
            if (i_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         mant_q  <= '0;
         exp_q   <= '0;
         lz_q    <= '0;
         idx_q   <= '0;
         zero_q  <= 1'b0;
         omant_q <= '0;
         oexp_q  <= '0;
         ozero_q <= 1'b0;
         ounf_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mant_q  <= mant_d;
         exp_q   <= exp_d;
         lz_q    <= lz_d;
         idx_q   <= idx_d;
         zero_q  <= zero_d;
         omant_q <= omant_d;
         oexp_q  <= oexp_d;
         ozero_q <= ozero_d;
         ounf_q  <= ounf_d;
      end
   end

   assign o_ready     = (state_q == IDLE);
   assign o_valid     = (state_q == DONE);
   assign o_mant      = omant_q;
   assign o_exp       = oexp_q;
   assign o_zero      = ozero_q;
   assign o_underflow = ounf_q;

endmodule
`default_nettype wire

// File: tb/tb_bfp16_norm_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_bfp16_norm_seq
// Brief  : Self-checking bench for bfp16_norm_seq with a behavioural model.
// Rev    : 1.0
// ============================================================================
module tb_bfp16_norm_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_valid = 1'b0;
   logic        i_ready = 1'b0;
   logic [15:0] i_mant = '0;
   logic [7:0]  i_exp = '0;
   logic        o_ready, o_valid, o_zero, o_underflow;
   logic [15:0] o_mant;
   logic [7:0]  o_exp;

   int n_cmp = 0;
   int n_bad = 0;

   // model expectations for the operand in flight
   logic        exp_active = 1'b0;
   logic [15:0] m_mant;
   logic [7:0]  m_exp;
   logic        m_zero, m_unf;
   int          m_k;

   logic [15:0] last_mant;
   logic [7:0]  last_exp;
   logic        last_zero, last_unf;
   int          last_lat;

   always #5 clk = ~clk;

   bfp16_norm_seq #(.DATA_W(16), .EXP_W(8)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_mant      (i_mant),
      .i_exp       (i_exp),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_mant      (o_mant),
      .o_exp       (o_exp),
      .o_zero      (o_zero),
      .o_underflow (o_underflow)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Behavioural reference: count leading zeros bit by bit, then clamp.
   task automatic model(input logic [15:0] m, input logic [7:0] e,
                        output logic [15:0] om, output logic [7:0] oe,
                        output logic oz, output logic ou, output int k);
      int lz;
      int sh;
      lz = 0;
      while (lz < 16 && m[15-lz] == 1'b0) lz++;
      if (lz == 16) begin
         om = 16'h0; oe = 8'h0; oz = 1'b1; ou = 1'b0; k = 1;
      end else begin
         sh = (lz >= int'(e)) ? int'(e) : lz;
         om = m << sh;
         oe = 8'(int'(e) - sh);
         oz = 1'b0;
         ou = (lz >= int'(e));
         k  = lz / 8;
      end
   endtask

   always @(negedge clk) begin
      if (!rst && exp_active && o_valid) begin
         chk("mon_mant", 32'(o_mant), 32'(m_mant));
         chk("mon_exp", 32'(o_exp), 32'(m_exp));
         chk("mon_zero", 32'(o_zero), 32'(m_zero));
         chk("mon_unf", 32'(o_underflow), 32'(m_unf));
         chk("mon_ready_low", 32'(o_ready), 32'd0);
      end
   end

   // Called at a negedge in IDLE; returns at the negedge of cycle T+1.
   task automatic accept_op(input logic [15:0] m, input logic [7:0] e);
      model(m, e, m_mant, m_exp, m_zero, m_unf, m_k);
      exp_active = 1'b1;
      i_mant  = m;
      i_exp   = e;
      i_valid = 1'b1;
      chk("ready_idle", 32'(o_ready), 32'd1);
      @(negedge clk);
      i_valid = 1'b0;
      i_mant  = 16'($urandom);
      i_exp   = 8'($urandom);
   endtask

   task automatic finish_op(input int hold);
      int n;
      n = 1;
      while (!o_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      last_lat  = n;
      last_mant = o_mant;
      last_exp  = o_exp;
      last_zero = o_zero;
      last_unf  = o_underflow;
      chk("latency", 32'(n), 32'(m_k + 3));
      for (int h = 0; h < hold; h++) begin
         i_ready = 1'b0;
         i_valid = 1'b1;
         i_mant  = 16'($urandom);
         i_exp   = 8'($urandom);
         @(negedge clk);
         chk("bp_valid_held", 32'(o_valid), 32'd1);
         chk("bp_stable", {o_mant, o_exp, 7'd0, o_zero}, {last_mant, last_exp, 7'd0, last_zero});
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
      exp_active = 1'b0;
      chk("drop_valid", 32'(o_valid), 32'd0);
      chk("back_idle", 32'(o_ready), 32'd1);
   endtask

   task automatic run_op(input logic [15:0] m, input logic [7:0] e, input int hold);
      accept_op(m, e);
      finish_op(hold);
   endtask

   initial begin
      logic [15:0] rm;
      logic [7:0]  re;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", 32'(o_ready), 32'd1);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_outs", {o_mant, o_exp, 6'd0, o_zero, o_underflow}, 32'd0);

      run_op(16'h8000, 8'd10, 0);
      chk("t1_mant", 32'(last_mant), 32'h8000);
      chk("t1_exp", 32'(last_exp), 32'd10);
      chk("t1_flags", {30'd0, last_zero, last_unf}, 32'd0);
      chk("t1_lat", 32'(last_lat), 32'd3);

      run_op(16'h0013, 8'd20, 0);
      chk("t2_mant", 32'(last_mant), 32'h9800);
      chk("t2_exp", 32'(last_exp), 32'd9);
      chk("t2_lat", 32'(last_lat), 32'd4);

      run_op(16'h0000, 8'd5, 0);
      chk("t3_zero", 32'(last_zero), 32'd1);
      chk("t3_mant_exp", {8'd0, last_mant, last_exp}, 32'd0);
      chk("t3_unf", 32'(last_unf), 32'd0);
      chk("t3_lat", 32'(last_lat), 32'd4);

      run_op(16'h0100, 8'd3, 0);
      chk("t4_mant", 32'(last_mant), 32'h0800);
      chk("t4_exp", 32'(last_exp), 32'd0);
      chk("t4_unf", 32'(last_unf), 32'd1);
      chk("t4_lat", 32'(last_lat), 32'd3);

      run_op(16'h0013, 8'd20, 5);
      chk("t5_mant", 32'(last_mant), 32'h9800);

      accept_op(16'h0001, 8'd5);
      rst = 1'b1;
      @(negedge clk);
      exp_active = 1'b0;
      chk("midrst_valid", 32'(o_valid), 32'd0);
      chk("midrst_ready", 32'(o_ready), 32'd1);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_idle", 32'(o_ready), 32'd1);
      run_op(16'h4000, 8'd7, 0);
      chk("t6_mant", 32'(last_mant), 32'h8000);
      chk("t6_exp", 32'(last_exp), 32'd6);
      chk("t6_lat", 32'(last_lat), 32'd3);

      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 3))
            0:       rm = 16'h0;
            1:       rm = 16'($urandom) >> $urandom_range(0, 15);
            default: rm = 16'($urandom) >> $urandom_range(6, 15);
         endcase
         re = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom);
         run_op(rm, re, $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
      $fatal(1);
   end

endmodule
`default_nettype wire
